// File: rtl/core_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_irq_pkg
// Description : Shared constants, types and helpers for the core_irq_ctrl
//               interrupt front-end (default vectors, channel id type and the
//               fixed-priority encoder).
// Revision    : 1.0 - initial release
// ============================================================================
package core_irq_pkg;

  // Default 65xx vector-low addresses
  localparam logic [15:0] NMI_VEC = 16'hFFFA;
  localparam logic [15:0] RES_VEC = 16'hFFFC;
  localparam logic [15:0] IRQ_VEC = 16'hFFFE;

  typedef bit [2:0] irq_id_type;

  // Lowest set index wins. An all-zero input returns 0; callers qualify the
  // result with a separate "any eligible" term.
  function automatic irq_id_type prio_encode(input logic [7:0] eligible);
    irq_id_type id;
    id = '0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) begin
        id = irq_id_type'(i);
      end
    end
    return id;
  endfunction

endpackage : core_irq_pkg
`default_nettype wire

// File: rtl/core_irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : core_irq_sync
// Description : Multi-stage synchroniser for one active-low interrupt line,
//               with a falling-edge pulse derived from the synced value.
// Ports       : I_clock   - system clock
//               I_reset   - asynchronous active-high reset (flops go to 1)
//               I_src     - raw asynchronous line, active-low
//               O_synced  - synchronised line
//               O_fall    - one-clock pulse on a synced 1->0 transition
// Revision    : 1.0 - initial release
// ============================================================================
module core_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic I_clock,
  input  logic I_reset,
  input  logic I_src,
  output logic O_synced,
  output logic O_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Flops reset to the idle (high) level so that reset release never
  // fabricates a falling edge.
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], I_src};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign O_synced = r_sync[SYNC_STAGES-1];
  assign O_fall   = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule : core_irq_sync
`default_nettype wire

// File: rtl/core_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : core_irq_ctrl
// Description : N-channel interrupt front-end for the 65xx core. Synchronises
//               active-low sources, latches edge channels, applies masking,
//               arbitrates by fixed priority and presents a registered
//               request / id / vector to the core's T0 logic.
// Ports       : I_clock, I_reset  - clock, asynchronous active-high reset
//               I_step            - core cycle enable for output registers
//               I_src             - raw interrupt lines, active-low
//               I_mask            - per-channel mask, 1 = masked
//               I_iflag           - core P.I flag, blocks maskable channels
//               I_ack             - core taking the interrupt (with I_step)
//               O_req             - forced-BRK request pending
//               O_is_reset        - current request is the reset sequence
//               O_id              - serviced channel, CHANNELS if none/reset
//               O_vec_lo/O_vec_hi - vector address and address + 1
//               O_pending         - raw pending bits
// Revision    : 1.0 - initial release
// ============================================================================
module core_irq_ctrl
  import core_irq_pkg::*;
#(
  parameter int                     CHANNELS     = 4,
  parameter logic [CHANNELS-1:0]    EDGE_MODE    = 4'b0001,
  parameter logic [CHANNELS-1:0]    NON_MASKABLE = 4'b0001,
  parameter logic [16*CHANNELS-1:0] VEC_TABLE    = {IRQ_VEC, IRQ_VEC, IRQ_VEC, NMI_VEC},
  parameter logic [15:0]            RESET_VEC    = RES_VEC,
  parameter logic [15:0]            BRK_VEC      = IRQ_VEC,
  parameter int                     SYNC_STAGES  = 2
) (
  input  logic                I_clock,
  input  logic                I_reset,
  input  logic                I_step,
  input  logic [CHANNELS-1:0] I_src,
  input  logic [CHANNELS-1:0] I_mask,
  input  logic                I_iflag,
  input  logic                I_ack,
  output logic                O_req,
  output logic                O_is_reset,
  output logic [2:0]          O_id,
  output logic [15:0]         O_vec_lo,
  output logic [15:0]         O_vec_hi,
  output logic [CHANNELS-1:0] O_pending
);

  localparam logic [2:0]          c_none_id   = 3'(CHANNELS);
  localparam logic [CHANNELS-1:0] c_edge_mask = EDGE_MODE;

  logic [CHANNELS-1:0] w_synced;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_edge_next;
  logic [CHANNELS-1:0] w_pend_next;
  logic [CHANNELS-1:0] w_eligible;
  logic [7:0]          w_elig8;
  logic                w_ack;
  logic                w_reset_next;
  irq_id_type          w_win_id;
  logic [15:0]         w_win_vec;

  logic                w_nxt_req;
  logic                w_nxt_is_reset;
  logic [2:0]          w_nxt_id;
  logic [15:0]         w_nxt_vec;

  logic                r_reset_flag;
  logic [CHANNELS-1:0] r_pending;
  logic                r_req;
  logic                r_is_reset;
  logic [2:0]          r_id;
  logic [15:0]         r_vec_lo;
  logic [15:0]         r_vec_hi;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    core_irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .I_clock  (I_clock),
      .I_reset  (I_reset),
      .I_src    (I_src[k]),
      .O_synced (w_synced[k]),
      .O_fall   (w_fall[k])
    );
  end

  // Ack only counts when a request is actually presented; a BRK with no
  // request (O_req = 0) leaves all state alone.
  assign w_ack = I_ack & I_step & r_req;

  always_comb begin
    w_clr = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_ack && !r_is_reset && (r_id == 3'(k))) begin
        w_clr[k] = 1'b1;
      end
    end
  end

  // Set is OR-ed after the clear so a new edge on the ack clock survives.
  assign w_edge_next  = (w_fall | (r_pending & ~w_clr)) & c_edge_mask;
  // Level channels track the synced line directly and are never latched.
  assign w_pend_next  = w_edge_next | (~w_synced & ~c_edge_mask);
  assign w_eligible   = w_pend_next & (NON_MASKABLE | ~(I_mask | {CHANNELS{I_iflag}}));
  assign w_reset_next = r_reset_flag & ~(w_ack & r_is_reset);

  always_comb begin
    w_elig8                 = '0;
    w_elig8[CHANNELS-1:0]   = w_eligible;
  end

  assign w_win_id = prio_encode(w_elig8);

  always_comb begin
    w_win_vec = BRK_VEC;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_win_id == 3'(k)) begin
        w_win_vec = VEC_TABLE[16*k +: 16];
      end
    end
  end

  // Arbitration: pending reset overrides everything, then lowest index.
  always_comb begin
    w_nxt_req      = 1'b0;
    w_nxt_is_reset = 1'b0;
    w_nxt_id       = c_none_id;
    w_nxt_vec      = BRK_VEC;
    if (w_reset_next) begin
      w_nxt_req      = 1'b1;
      w_nxt_is_reset = 1'b1;
      w_nxt_vec      = RESET_VEC;
    end else if (|w_eligible) begin
      w_nxt_req = 1'b1;
      w_nxt_id  = w_win_id;
      w_nxt_vec = w_win_vec;
    end
  end

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      r_reset_flag <= 1'b1;
      r_pending    <= '0;
      r_req        <= 1'b1;
      r_is_reset   <= 1'b1;
      r_id         <= c_none_id;
      r_vec_lo     <= RESET_VEC;
      r_vec_hi     <= RESET_VEC + 16'd1;
    end else begin
      r_reset_flag <= w_reset_next;
      r_pending    <= w_edge_next;
      // Outputs are frozen between core steps so the core samples a
      // stable request for the whole cycle.
      if (I_step) begin
        r_req      <= w_nxt_req;
        r_is_reset <= w_nxt_is_reset;
        r_id       <= w_nxt_id;
        r_vec_lo   <= w_nxt_vec;
        r_vec_hi   <= w_nxt_vec + 16'd1;
      end
    end
  end

  assign O_req      = r_req;
  assign O_is_reset = r_is_reset;
  assign O_id       = r_id;
  assign O_vec_lo   = r_vec_lo;
  assign O_vec_hi   = r_vec_hi;
  assign O_pending  = r_pending | (~w_synced & ~c_edge_mask);

endmodule : core_irq_ctrl
`default_nettype wire

// File: tb/tb_core_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_irq_ctrl
// Description : Self-checking bench for core_irq_ctrl (default parameters:
//               4 channels, ch0 edge/non-maskable NMI, ch1..3 level IRQ).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_irq_ctrl;

  typedef struct {
    logic        step;
    logic [3:0]  src;
    logic [3:0]  mask;
    logic        iflag;
    logic        ack;
    logic        e_req;
    logic        e_rst;
    logic [2:0]  e_id;
    logic [15:0] e_vec;
    logic [3:0]  e_pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic [3:0]  src = 4'hF;
  logic [3:0]  mask = 4'h0;
  logic        iflag = 1'b1;
  logic        ack = 1'b0;
  logic        req;
  logic        is_reset;
  logic [2:0]  id;
  logic [15:0] vec_lo;
  logic [15:0] vec_hi;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t tbl[$];

  core_irq_ctrl dut (
    .I_clock    (clk),
    .I_reset    (rst),
    .I_step     (step),
    .I_src      (src),
    .I_mask     (mask),
    .I_iflag    (iflag),
    .I_ack      (ack),
    .O_req      (req),
    .O_is_reset (is_reset),
    .O_id       (id),
    .O_vec_lo   (vec_lo),
    .O_vec_hi   (vec_hi),
    .O_pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic [3:0] sr, input logic [3:0] m,
                     input logic f, input logic a, input logic er, input logic ers,
                     input logic [2:0] ei, input logic [15:0] ev, input logic [3:0] ep);
    vec_t v;
    v.step = s; v.src = sr; v.mask = m; v.iflag = f; v.ack = a;
    v.e_req = er; v.e_rst = ers; v.e_id = ei; v.e_vec = ev; v.e_pend = ep;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic e_req, input logic e_rst,
                       input logic [2:0] e_id, input logic [15:0] e_vec,
                       input logic [3:0] e_pend);
    logic [15:0] e_hi;
    e_hi = e_vec + 16'd1;
    n_checks++;
    if ({req, is_reset, id, vec_lo, vec_hi, pending} !==
        {e_req, e_rst, e_id, e_vec, e_hi, e_pend}) begin
      $display("FAIL %s: got req=%b rst=%b id=%0d lo=%h hi=%h pend=%b, expected req=%b rst=%b id=%0d lo=%h hi=%h pend=%b",
               name, req, is_reset, id, vec_lo, vec_hi, pending,
               e_req, e_rst, e_id, e_vec, e_hi, e_pend);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    // step, src, mask, iflag, ack | req, rst, id, vec_lo, pending
    add(1, 4'hF, 4'h0, 1, 0,  1, 1, 3'd4, 16'hFFFC, 4'h0); // v0 reset held
    add(0, 4'hF, 4'h0, 1, 1,  1, 1, 3'd4, 16'hFFFC, 4'h0); // v1 ack w/o step
    add(1, 4'hF, 4'h0, 1, 1,  0, 0, 3'd4, 16'hFFFE, 4'h0); // v2 reset ack
    add(1, 4'hF, 4'h0, 1, 1,  0, 0, 3'd4, 16'hFFFE, 4'h0); // v3 BRK ack ignored
    add(0, 4'hE, 4'h0, 1, 0,  0, 0, 3'd4, 16'hFFFE, 4'h0); // v4 ch0 low
    add(0, 4'hE, 4'h0, 1, 0,  0, 0, 3'd4, 16'hFFFE, 4'h0); // v5
    add(0, 4'hE, 4'h0, 1, 0,  0, 0, 3'd4, 16'hFFFE, 4'h1); // v6 pending, frozen
    add(1, 4'hF, 4'h0, 1, 0,  1, 0, 3'd0, 16'hFFFA, 4'h1); // v7 NMI presented
    add(1, 4'hF, 4'h0, 1, 0,  1, 0, 3'd0, 16'hFFFA, 4'h1); // v8 held
    add(1, 4'hF, 4'h0, 1, 1,  0, 0, 3'd4, 16'hFFFE, 4'h0); // v9 NMI ack
    add(1, 4'hD, 4'h0, 0, 0,  0, 0, 3'd4, 16'hFFFE, 4'h0); // v10 ch1 level low
    add(1, 4'hD, 4'h0, 0, 0,  0, 0, 3'd4, 16'hFFFE, 4'h2); // v11
    add(1, 4'hD, 4'h0, 0, 0,  1, 0, 3'd1, 16'hFFFE, 4'h2); // v12 IRQ presented
    add(1, 4'hD, 4'h0, 0, 1,  1, 0, 3'd1, 16'hFFFE, 4'h2); // v13 level survives ack
    add(1, 4'hD, 4'h0, 1, 0,  0, 0, 3'd4, 16'hFFFE, 4'h2); // v14 iflag blocks
    add(1, 4'hD, 4'h2, 0, 0,  0, 0, 3'd4, 16'hFFFE, 4'h2); // v15 mask blocks
    add(0, 4'hD, 4'h0, 0, 0,  0, 0, 3'd4, 16'hFFFE, 4'h2); // v16 frozen
    add(1, 4'hD, 4'h0, 0, 0,  1, 0, 3'd1, 16'hFFFE, 4'h2); // v17 unmasked
    add(0, 4'hC, 4'h0, 0, 0,  1, 0, 3'd1, 16'hFFFE, 4'h2); // v18 ch0 falls too
    add(0, 4'hC, 4'h0, 0, 0,  1, 0, 3'd1, 16'hFFFE, 4'h2); // v19
    add(1, 4'hC, 4'h0, 0, 0,  1, 0, 3'd0, 16'hFFFA, 4'h3); // v20 ch0 wins
    add(1, 4'hC, 4'h0, 0, 1,  1, 0, 3'd1, 16'hFFFE, 4'h2); // v21 then ch1
    add(1, 4'hD, 4'h0, 0, 0,  1, 0, 3'd1, 16'hFFFE, 4'h2); // v22
    add(1, 4'hF, 4'h0, 0, 0,  1, 0, 3'd1, 16'hFFFE, 4'h2); // v23 ch1 released
    add(1, 4'hF, 4'h0, 0, 0,  1, 0, 3'd1, 16'hFFFE, 4'h0); // v24
    add(1, 4'hF, 4'h0, 0, 0,  0, 0, 3'd4, 16'hFFFE, 4'h0); // v25 idle

    tick();
    tick();
    check("reset", 1, 1, 3'd4, 16'hFFFC, 4'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step  = tbl[i].step;
      src   = tbl[i].src;
      mask  = tbl[i].mask;
      iflag = tbl[i].iflag;
      ack   = tbl[i].ack;
      tick();
      ack = 1'b0;
      check($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_rst, tbl[i].e_id,
            tbl[i].e_vec, tbl[i].e_pend);
    end

    // New ch0 edge landing on the same clock as the ch0 ack
    step = 1'b1; iflag = 1'b1; mask = 4'h0; ack = 1'b0;
    src = 4'hE;
    repeat (3) tick();
    check("nmi_present", 1, 0, 3'd0, 16'hFFFA, 4'h1);
    src = 4'hF;
    repeat (3) tick();
    check("nmi_held", 1, 0, 3'd0, 16'hFFFA, 4'h1);
    src = 4'hE;
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_edge_coincide", 1, 0, 3'd0, 16'hFFFA, 4'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_after", 0, 0, 3'd4, 16'hFFFE, 4'h0);

    // Reset in the middle of a presented NMI
    src = 4'hF;
    repeat (3) tick();
    src = 4'hE;
    repeat (3) tick();
    check("pre_reset", 1, 0, 3'd0, 16'hFFFA, 4'h1);
    rst = 1'b1;
    #1;
    check("async_reset", 1, 1, 3'd4, 16'hFFFC, 4'h0);
    src = 4'hF;
    tick();
    rst = 1'b0;
    tick();
    check("after_reset", 1, 1, 3'd4, 16'hFFFC, 4'h0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("reset_ack2", 0, 0, 3'd4, 16'hFFFE, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_core_irq_ctrl
`default_nettype wire
